riscv_divider: RTL and testbench

RISCV_DIVIDER -- requirements
Module: riscv_divider

---
 rtl/riscv_divider.sv | 81 ++++++++
 tb/tb_riscv_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_divider.sv
// riscv_divider: iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants
module riscv_divider #(
  parameter int XLEN = 64
) (
  input  logic            i_riscv_div_clk,
  input  logic            i_riscv_div_rst,
  input  logic            i_riscv_div_en,
  input  logic [1:0]      i_riscv_div_ctrl,
  input  logic            i_riscv_div_word,
  input  logic [XLEN-1:0] i_riscv_div_rs1data,
  input  logic [XLEN-1:0] i_riscv_div_rs2data,
  output logic [XLEN-1:0] o_riscv_div_result,
  output logic            o_riscv_div_valid,
  output logic            o_riscv_div_busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic word_r, is_rem, neg_q, neg_r;
  logic [XLEN-1:0] q, r, d;
  logic is_signed, a_neg, b_neg, div_zero, ovf, special, last;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, q_n, r_n, q_fin, r_fin, fin, spec_res;
  logic [XLEN:0] r_sh, diff;
  function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction
  assign is_signed = ~i_riscv_div_ctrl[0];
  assign a_ext = i_riscv_div_word ? {{(XLEN-32){is_signed & i_riscv_div_rs1data[31]}}, i_riscv_div_rs1data[31:0]} : i_riscv_div_rs1data;
  assign b_ext = i_riscv_div_word ? {{(XLEN-32){is_signed & i_riscv_div_rs2data[31]}}, i_riscv_div_rs2data[31:0]} : i_riscv_div_rs2data;
  assign a_neg = is_signed & a_ext[XLEN-1];
  assign b_neg = is_signed & b_ext[XLEN-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;
  assign div_zero = b_ext == '0;
  assign ovf = is_signed && b_ext == '1 && a_ext == (i_riscv_div_word ? MIN_W : MIN_D);
  assign special = div_zero | ovf;
  assign spec_res = div_zero ? (i_riscv_div_ctrl[1] ? a_ext : '1) : (i_riscv_div_ctrl[1] ? '0 : a_ext);
  assign r_sh = {r, q[XLEN-1]};
  assign diff = r_sh - {1'b0, d};
  assign r_n = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign q_n = {q[XLEN-2:0], ~diff[XLEN]};
  assign q_fin = neg_q ? -q_n : q_n;
  assign r_fin = neg_r ? -r_n : r_n;
  assign fin = is_rem ? r_fin : q_fin;
  assign last = cnt == CW'(1);
  assign o_riscv_div_busy = state == CALC;
  assign o_riscv_div_valid = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (i_riscv_div_en ? (special ? DONE : CALC) : IDLE)
            : state == CALC ? (!i_riscv_div_en ? IDLE : last ? DONE : CALC)
            : IDLE;
  end
  always_ff @(posedge i_riscv_div_clk) begin
    if (i_riscv_div_rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge i_riscv_div_clk) begin
    if (i_riscv_div_rst) begin
      cnt <= '0;
      o_riscv_div_result <= '0;
    end else if (state == IDLE && i_riscv_div_en) begin
      cnt <= i_riscv_div_word ? CW'(32) : CW'(XLEN);
      word_r <= i_riscv_div_word;
      is_rem <= i_riscv_div_ctrl[1];
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      q <= i_riscv_div_word ? a_mag << (XLEN - 32) : a_mag;
      r <= '0;
      d <= b_mag;
      if (special) o_riscv_div_result <= fmt(i_riscv_div_word, spec_res);
    end else if (state == CALC && i_riscv_div_en) begin
      cnt <= cnt - CW'(1);
      q <= q_n;
      r <= r_n;
      if (last) o_riscv_div_result <= fmt(word_r, fin);
    end
  end
endmodule

// File: tb/tb_riscv_divider.sv
// tb_riscv_divider: directed and randomized checks of riscv_divider against an arithmetic reference model
module tb_riscv_divider;
  logic clk = 0, rst = 1, en = 0, word = 0;
  logic [1:0] ctrl = 0;
  logic [63:0] rs1 = 0, rs2 = 0, result;
  logic valid, busy;
  logic [63:0] last_exp = 0;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  riscv_divider #(.XLEN(64)) dut (
    .i_riscv_div_clk(clk),
    .i_riscv_div_rst(rst),
    .i_riscv_div_en(en),
    .i_riscv_div_ctrl(ctrl),
    .i_riscv_div_word(word),
    .i_riscv_div_rs1data(rs1),
    .i_riscv_div_rs2data(rs2),
    .o_riscv_div_result(result),
    .o_riscv_div_valid(valid),
    .o_riscv_div_busy(busy)
  );
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic is_special(input logic [1:0] c, input logic w, input logic [63:0] a, input logic [63:0] b);
    if (w) return b[31:0] == 0 || (!c[0] && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF);
    return b == 0 || (!c[0] && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF);
  endfunction
  function automatic logic [63:0] model(input logic [1:0] c, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] ua, ub, r32;
    logic signed [31:0] sa, sb;
    logic signed [63:0] la, lb;
    logic [63:0] r64;
    ua = a[31:0]; ub = b[31:0]; sa = ua; sb = ub; la = a; lb = b;
    if (w) begin
      if (ub == 0) r32 = c[1] ? ua : 32'hFFFFFFFF;
      else if (!c[0] && ua == 32'h80000000 && ub == 32'hFFFFFFFF) r32 = c[1] ? 32'h0 : ua;
      else case (c)
        2'd0: r32 = sa / sb;
        2'd1: r32 = ua / ub;
        2'd2: r32 = sa % sb;
        default: r32 = ua % ub;
      endcase
      return {{32{r32[31]}}, r32};
    end
    if (b == 0) r64 = c[1] ? a : 64'hFFFFFFFFFFFFFFFF;
    else if (!c[0] && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF) r64 = c[1] ? 64'h0 : a;
    else case (c)
      2'd0: r64 = la / lb;
      2'd1: r64 = a / b;
      2'd2: r64 = la % lb;
      default: r64 = a % b;
    endcase
    return r64;
  endfunction
  task automatic wait_valid(inout int lat);
    while (valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic do_op(input logic [1:0] c, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input string tag, output logic [63:0] got);
    int lat;
    logic bz;
    logic [63:0] exp;
    exp = model(c, w, a, b);
    ctrl = c; word = w; rs1 = a; rs2 = b; en = 1;
    @(posedge clk); #1;
    lat = 1;
    bz = busy;
    ctrl = 2'($urandom); word = 1'($urandom); rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
    wait_valid(lat);
    chk({tag, " latency"}, 64'(lat), is_special(c, w, a, b) ? 64'd1 : w ? 64'd33 : 64'd65);
    chk({tag, " busy"}, 64'(bz), is_special(c, w, a, b) ? 64'd0 : 64'd1);
    chk({tag, " result"}, result, exp);
    got = result;
    en = 0;
    @(posedge clk); #1;
    chk({tag, " pulse width"}, 64'(valid), 64'd0);
    chk({tag, " hold"}, result, exp);
    last_exp = exp;
  endtask
  initial begin
    logic [63:0] got, a, b;
    logic [1:0] c;
    logic w, saw;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result", result, 64'd0);
    rst = 0;
    do_op(2'd0, 1'b0, -64'sd20, 64'd3, "DIV -20/3", got);
    chk("DIV -20/3 const", got, 64'hFFFFFFFFFFFFFFFA);
    do_op(2'd2, 1'b0, -64'sd20, 64'd3, "REM -20/3", got);
    chk("REM -20/3 const", got, 64'hFFFFFFFFFFFFFFFE);
    do_op(2'd1, 1'b1, 64'hFFFFFFFF00000010, 64'd4, "DIVUW", got);
    chk("DIVUW const", got, 64'd4);
    do_op(2'd1, 1'b0, 64'd12345, 64'd0, "DIVU by 0", got);
    chk("DIVU by 0 const", got, 64'hFFFFFFFFFFFFFFFF);
    do_op(2'd3, 1'b0, 64'd7, 64'd0, "REMU by 0", got);
    chk("REMU by 0 const", got, 64'd7);
    do_op(2'd0, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, "DIV ovf", got);
    chk("DIV ovf const", got, 64'h8000000000000000);
    do_op(2'd2, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, "REM ovf", got);
    chk("REM ovf const", got, 64'd0);
    ctrl = 2'd1; word = 0; rs1 = 64'd100; rs2 = 64'd7; en = 1;
    @(posedge clk); #1;
    lat = 1;
    wait_valid(lat);
    chk("b2b first latency", 64'(lat), 64'd65);
    chk("b2b first result", result, 64'd14);
    rs1 = 64'd9; rs2 = 64'd3;
    @(posedge clk); #1;
    lat++;
    chk("b2b first pulse width", 64'(valid), 64'd0);
    wait_valid(lat);
    chk("b2b second latency", 64'(lat), 64'd131);
    chk("b2b second result", result, 64'd3);
    en = 0;
    @(posedge clk); #1;
    chk("b2b second pulse width", 64'(valid), 64'd0);
    last_exp = 64'd3;
    ctrl = 2'd1; word = 0; rs1 = 64'd1000; rs2 = 64'd10; en = 1;
    @(posedge clk); #1;
    lat = 1;
    repeat (9) begin
      @(posedge clk); #1;
      lat++;
    end
    rst = 1;
    @(posedge clk); #1;
    lat++;
    rst = 0;
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset valid", 64'(valid), 64'd0);
    chk("mid reset result", result, 64'd0);
    wait_valid(lat);
    chk("post reset latency", 64'(lat), 64'd76);
    chk("post reset result", result, 64'd100);
    en = 0;
    @(posedge clk); #1;
    last_exp = 64'd100;
    ctrl = 2'd0; word = 0; rs1 = 64'd777; rs2 = 64'd5; en = 1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    en = 0;
    @(posedge clk); #1;
    chk("abort busy", 64'(busy), 64'd0);
    saw = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (valid === 1'b1) saw = 1;
    end
    chk("abort no valid", 64'(saw), 64'd0);
    chk("abort result held", result, last_exp);
    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom); w = 1'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = w ? {b[63:32], 32'h0} : 64'h0;
        1: b = w ? {b[63:32], 32'hFFFFFFFF} : 64'hFFFFFFFFFFFFFFFF;
        2: begin
          a = w ? {a[63:32], 32'h80000000} : 64'h8000000000000000;
          b = w ? {b[63:32], 32'hFFFFFFFF} : 64'hFFFFFFFFFFFFFFFF;
        end
        3: b = 64'($urandom_range(1, 20));
        4: a = a >> $urandom_range(0, 63);
        default: ;
      endcase
      do_op(c, w, a, b, $sformatf("rand%0d c=%0d w=%0d", i, c, w), got);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
